// File: rtl/pov_pkg.sv
`timescale 1ns/1ps
// pov_pkg: shared state encoding, log2 helper and geometry widths
// for the POV globe column scheduler.
package pov_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE    = 2'd0,
      STATE_MEASURE = 2'd1,
      STATE_RUN     = 2'd2
   } state_t;

   localparam int POV_COLUMNS_DEF     = 64;
   localparam int POV_AMOUNT_LEDS_DEF = 5;

   // Ceiling log2, usable in constant expressions.
   function automatic int pov_log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Width of a column index.
   function automatic int pov_col_w(input int columns);
      return pov_log2(columns);
   endfunction

   // Width of a colour-memory base address.
   function automatic int pov_addr_w(input int columns, input int leds);
      return pov_log2(columns * leds);
   endfunction

endpackage

// File: rtl/pov_hall_sync.sv
`timescale 1ns/1ps
// pov_hall_sync: brings the raw hall sensor into CLOCK_50, detects its
// rising edge and rejects edges that arrive before MIN_PERIOD cycles
// of the current revolution have elapsed (magnet bounce / noise).
module pov_hall_sync #(
   parameter int PERIOD_WIDTH = 26,
   parameter int MIN_PERIOD   = 500_000
) (
   input  logic                    CLOCK_50,
   input  logic                    reset_n,
   input  logic                    hall_in,
   input  logic [PERIOD_WIDTH-1:0] period_cnt,
   output logic                    hall_event
);

   localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

   logic sync_1, sync_2, sync_3;

   // Two-flop synchroniser, edge-history flop and registered debounced event.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         sync_3     <= 1'b0;
         hall_event <= 1'b0;
      end else begin
         sync_1     <= hall_in;
         sync_2     <= sync_1;
         sync_3     <= sync_2;
         hall_event <= sync_2 & ~sync_3 & (period_cnt >= MIN_P);
      end
   end

endmodule

// File: rtl/pov_column_scheduler.sv
`timescale 1ns/1ps
// pov_column_scheduler: measures the globe revolution period from the hall
// pulse and issues one LED-driver frame request per column slot.
// Optional build macro POV_PHASE_OFFSET_EN adds a phase_offset input that
// rotates the image by offsetting the column used for the memory address.
//
// state         | meaning
// STATE_IDLE    | stopped; waiting for a first hall edge
// STATE_MEASURE | one edge seen; timing the first full revolution
// STATE_RUN     | locked; issuing columns on the column timer
module pov_column_scheduler
   import pov_pkg::*;
#(
   parameter int SYSTEM_CLOCK  = 50_000_000,
   parameter int AMOUNT_LEDS   = POV_AMOUNT_LEDS_DEF,
   parameter int COLUMNS       = POV_COLUMNS_DEF,
   parameter int PERIOD_WIDTH  = 26,
   parameter int MIN_PERIOD    = SYSTEM_CLOCK / 100,
   parameter int TIMEOUT_COUNT = SYSTEM_CLOCK
) (
   input  logic                                           CLOCK_50,
   input  logic                                           reset_n,
   input  logic                                           hall_in,
   input  logic                                           driver_busy,
   input  logic                                           driver_done,
`ifdef POV_PHASE_OFFSET_EN
   input  logic [pov_col_w(COLUMNS)-1:0]                  phase_offset,
`endif
   output logic                                           frame_start,
   output logic [pov_addr_w(COLUMNS, AMOUNT_LEDS)-1:0]    frame_base,
   output logic [pov_col_w(COLUMNS)-1:0]                  column_index,
   output logic                                           spinning,
   output logic [PERIOD_WIDTH-1:0]                        rev_period,
   output logic [7:0]                                     overrun_count
);

   localparam int COL_W  = pov_col_w(COLUMNS);
   localparam int ADDR_W = pov_addr_w(COLUMNS, AMOUNT_LEDS);
   localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(COLUMNS - 1);
   localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_P = PERIOD_WIDTH'(TIMEOUT_COUNT);

   state_t                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] period_cnt, meas_period;
   logic [PERIOD_WIDTH-1:0] col_timer_q, col_timer_d, rev_period_d;
   logic [COL_W-1:0]        column_d, col_addr;
   logic [ADDR_W-1:0]       frame_base_d;
   logic [7:0]              overrun_d;
   logic                    hall_event, want_issue, issue;
   logic                    spinning_d, in_flight_q, in_flight_d;

   // Column spacing minus one; a degenerate zero interval fires every cycle.
   function automatic logic [PERIOD_WIDTH-1:0] timer_load(input logic [PERIOD_WIDTH-1:0] period);
      logic [PERIOD_WIDTH-1:0] interval;
      interval = period >> COL_W;
      return (interval == '0) ? '0 : interval - PERIOD_WIDTH'(1);
   endfunction

   pov_hall_sync #(
      .PERIOD_WIDTH(PERIOD_WIDTH),
      .MIN_PERIOD  (MIN_PERIOD)
   ) u_hall_sync (
      .CLOCK_50  (CLOCK_50),
      .reset_n   (reset_n),
      .hall_in   (hall_in),
      .period_cnt(period_cnt),
      .hall_event(hall_event)
   );

   // The cycle carrying the hall event closes the period, hence the +1.
   assign meas_period = period_cnt + PERIOD_WIDTH'(1);

`ifdef POV_PHASE_OFFSET_EN
   logic [COL_W-1:0] offset_q, offset_d;
   assign offset_d = hall_event ? phase_offset : offset_q;

   // Phase offset is captured once per revolution so the image cannot tear mid-turn.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) offset_q <= '0;
      else          offset_q <= offset_d;
   end
`endif

   // Revolution timer: restarts on each accepted hall edge, parks at the timeout value.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n)                     period_cnt <= '0;
      else if (hall_event)              period_cnt <= '0;
      else if (period_cnt != TIMEOUT_P) period_cnt <= period_cnt + PERIOD_WIDTH'(1);
   end

   // Next-state, column timer and frame-issue decision.
   always_comb begin
      state_d      = state_q;
      col_timer_d  = col_timer_q;
      column_d     = column_index;
      rev_period_d = rev_period;
      spinning_d   = spinning;
      want_issue   = 1'b0;
      case (state_q)
         STATE_IDLE: begin
            if (hall_event) state_d = STATE_MEASURE;
         end
         STATE_MEASURE, STATE_RUN: begin
            if (hall_event) begin
               state_d      = STATE_RUN;
               rev_period_d = meas_period;
               column_d     = '0;
               col_timer_d  = timer_load(meas_period);
               spinning_d   = 1'b1;
               want_issue   = 1'b1;
            end else if (period_cnt == TIMEOUT_P) begin
               state_d    = STATE_IDLE;
               column_d   = '0;
               spinning_d = 1'b0;
            end else if (state_q == STATE_RUN && column_index != LAST_COL) begin
               if (col_timer_q == '0) begin
                  column_d    = column_index + COL_W'(1);
                  col_timer_d = timer_load(rev_period);
                  want_issue  = 1'b1;
               end else begin
                  col_timer_d = col_timer_q - PERIOD_WIDTH'(1);
               end
            end
         end
         default: state_d = STATE_IDLE;
      endcase

      // in_flight is the registered value, so a same-cycle driver_done does not free the slot.
      issue       = want_issue && !in_flight_q && !driver_busy;
      in_flight_d = issue ? 1'b1 : (driver_done ? 1'b0 : in_flight_q);
      overrun_d   = (want_issue && !issue && overrun_count != 8'hFF) ?
                    overrun_count + 8'd1 : overrun_count;
`ifdef POV_PHASE_OFFSET_EN
      col_addr    = column_d + offset_d;
`else
      col_addr    = column_d;
`endif
      frame_base_d = issue ? ADDR_W'(col_addr * AMOUNT_LEDS) : frame_base;
   end

   // State register and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q       <= STATE_IDLE;
         col_timer_q   <= '0;
         column_index  <= '0;
         rev_period    <= '0;
         spinning      <= 1'b0;
         in_flight_q   <= 1'b0;
         frame_start   <= 1'b0;
         frame_base    <= '0;
         overrun_count <= '0;
      end else begin
         state_q       <= state_d;
         col_timer_q   <= col_timer_d;
         column_index  <= column_d;
         rev_period    <= rev_period_d;
         spinning      <= spinning_d;
         in_flight_q   <= in_flight_d;
         frame_start   <= issue;
         frame_base    <= frame_base_d;
         overrun_count <= overrun_d;
      end
   end

endmodule

// File: tb/tb_pov_column_scheduler.sv
`timescale 1ns/1ps
// tb_pov_column_scheduler: randomized revolutions against a reference model;
// expected frames go into a scoreboard queue that a monitor drains.
module tb_pov_column_scheduler;

   localparam int COLUMNS       = 4;
   localparam int AMOUNT_LEDS   = 5;
   localparam int MIN_PERIOD    = 20;
   localparam int TIMEOUT_COUNT = 1000;
   localparam int PERIOD_WIDTH  = 26;
   localparam int COL_W         = 2;
   localparam int ADDR_W        = 5;

   logic                    CLOCK_50 = 1'b0;
   logic                    reset_n;
   logic                    hall_in;
   logic                    driver_busy;
   logic                    driver_done = 1'b0;
   logic                    frame_start;
   logic [ADDR_W-1:0]       frame_base;
   logic [COL_W-1:0]        column_index;
   logic                    spinning;
   logic [PERIOD_WIDTH-1:0] rev_period;
   logic [7:0]              overrun_count;
`ifdef POV_PHASE_OFFSET_EN
   logic [COL_W-1:0]        phase_offset;
`endif

   typedef struct {
      int cyc;
      int base;
   } frame_t;

   frame_t exp_q[$];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   int     done_wait = 0;

   int prev_c = 0, exp_rev = 0, exp_int = 0, exp_ovr = 0, off = 0;
   bit have_prev = 0, locked = 0, exp_spin = 0;

   pov_column_scheduler #(
      .SYSTEM_CLOCK (50_000_000),
      .AMOUNT_LEDS  (AMOUNT_LEDS),
      .COLUMNS      (COLUMNS),
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .MIN_PERIOD   (MIN_PERIOD),
      .TIMEOUT_COUNT(TIMEOUT_COUNT)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset_n      (reset_n),
      .hall_in      (hall_in),
      .driver_busy  (driver_busy),
      .driver_done  (driver_done),
`ifdef POV_PHASE_OFFSET_EN
      .phase_offset (phase_offset),
`endif
      .frame_start  (frame_start),
      .frame_base   (frame_base),
      .column_index (column_index),
      .spinning     (spinning),
      .rev_period   (rev_period),
      .overrun_count(overrun_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge CLOCK_50);
   endtask

   // Reference model: a hall pulse whose rising edge is sampled at cycle c+1.
   task automatic model_pulse(input int c, input int busy_col);
      int     gap;
      frame_t f;
      gap = c - prev_c;
      if (have_prev && gap < MIN_PERIOD) return;
      if (have_prev && gap <= TIMEOUT_COUNT) begin
         locked   = 1;
         exp_spin = 1;
         exp_rev  = gap;
         exp_int  = gap / COLUMNS;
         for (int k = 0; k < COLUMNS; k++) begin
            if (k == busy_col) begin
               if (exp_ovr < 255) exp_ovr++;
            end else begin
               f.cyc  = c + 4 + k * exp_int;
               f.base = ((k + off) % COLUMNS) * AMOUNT_LEDS;
               exp_q.push_back(f);
            end
         end
      end else begin
         locked   = 0;
         exp_spin = 0;
      end
      prev_c    = c;
      have_prev = 1;
   endtask

   task automatic model_reset();
      have_prev = 0;
      locked    = 0;
      exp_spin  = 0;
      exp_rev   = 0;
      exp_ovr   = 0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_frame_base"}, frame_base, 0);
      check({tag, "_column_index"}, column_index, 0);
      check({tag, "_spinning"}, spinning, 0);
      check({tag, "_rev_period"}, rev_period, 0);
      check({tag, "_overrun_count"}, overrun_count, 0);
   endtask

   // One hall pulse now, optional glitch and busy window, then wait gap cycles.
   task automatic run_rev(input int gap, input bit glitch, input int busy_col);
      int c, t, g;
`ifdef POV_PHASE_OFFSET_EN
      phase_offset = COL_W'($urandom_range(0, COLUMNS - 1));
      off          = int'(phase_offset);
`endif
      c       = cyc;
      hall_in = 1;
      model_pulse(c, busy_col);
      wait_until(c + 3);
      hall_in = 0;
      wait_until(c + 6);
      check("spinning", spinning, exp_spin);
      check("rev_period", rev_period, exp_rev);
      check("column_start", column_index, 0);
      if (glitch) begin
         g = $urandom_range(8, 15);
         wait_until(c + g);
         hall_in = 1;
         model_pulse(cyc, -1);
         wait_until(c + g + 2);
         hall_in = 0;
      end
      if (locked && busy_col > 0) begin
         t = c + 4 + busy_col * exp_int;
         wait_until(t - 20);
         driver_busy = 1;
         wait_until(t + 20);
         driver_busy = 0;
      end
      wait_until(c + gap - 2);
      check("column_end", column_index, locked ? COLUMNS - 1 : 0);
      check("overrun_count", overrun_count, exp_ovr);
      check("rev_period_hold", rev_period, exp_rev);
      wait_until(c + gap);
   endtask

   // LED driver stand-in: reports completion a few cycles after each request.
   always @(negedge CLOCK_50) begin
      driver_done = 0;
      if (frame_start) done_wait = 8;
      else if (done_wait > 0) begin
         done_wait--;
         if (done_wait == 0) driver_done = 1;
      end
   end

   // Scoreboard monitor: every frame request must match the next expected frame.
   always @(negedge CLOCK_50) begin
      frame_t e;
      if (frame_start === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got frame base=%0d at cycle %0d, required none", frame_base, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.base != int'(frame_base)) begin
               errors++;
               $display("FAIL frame: got cycle=%0d base=%0d, required cycle=%0d base=%0d", cyc, frame_base, e.cyc, e.base);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset_n     = 0;
      hall_in     = 0;
      driver_busy = 0;
`ifdef POV_PHASE_OFFSET_EN
      phase_offset = '0;
`endif
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check_reset_outputs("reset_init");
      reset_n = 1;
      wait_until(40);

      // Arm, lock, glitch rejection, busy column 2.
      run_rev(400, 0, -1);
      run_rev(400, 0, -1);
      run_rev(400, 1, -1);
      run_rev(400, 0, 2);

      // Randomized revolutions.
      for (int i = 0; i < 4; i++) begin
         int bc;
         bc = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, COLUMNS - 1));
         run_rev(int'($urandom_range(380, 480)), 1'($urandom_range(0, 1)), bc);
      end

      // Stall: no hall edges for well over the timeout, then re-lock.
      wait_until(cyc + 700);
      check("timeout_spinning", spinning, 0);
      check("timeout_column", column_index, 0);
      run_rev(400, 0, -1);
      run_rev(400, 0, 1);

      // Reset in the middle of a revolution.
      c       = cyc;
      hall_in = 1;
      model_pulse(c, -1);
      wait_until(c + 3);
      hall_in = 0;
      wait_until(c + 4 + exp_int + 10);
      reset_n = 0;
      @(negedge CLOCK_50);
      check_reset_outputs("reset_run");
      model_reset();
      reset_n = 1;
      wait_until(cyc + 40);
      run_rev(400, 0, -1);
      run_rev(400, 0, -1);
      run_rev(400, 0, 3);

      check("frames_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pov_column_scheduler.md
Name: pov_column_scheduler

Overview:
- Sequences the WS2812 LED-strip driver of the POV globe.
- Measures the revolution period from a once-per-turn hall-sensor pulse and divides each revolution into COLUMNS equal slots.
- At each slot, issues one frame request to the LED driver with the memory base address of that column's colour data.
- Sits between the hall sensor input and the LED driver/Memory address path.

Parameters:
- SYSTEM_CLOCK, 50_000_000: input clock frequency in Hz.
- AMOUNT_LEDS, 5: LEDs per column; column stride in Memory words.
- COLUMNS, 64: columns per revolution; power of two.
- PERIOD_WIDTH, 26: width of the revolution-period counter.
- MIN_PERIOD, 500_000: hall edges closer together than this many cycles are ignored (10 ms debounce).
- TIMEOUT_COUNT, 50_000_000: no hall edge for this many cycles means the globe has stopped (1 s).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- hall_in  in  1  raw hall sensor, asynchronous, active-high pulse.
- driver_busy  in  1  LED driver is streaming a frame.
- driver_done  in  1  one-cycle pulse; LED driver finished its frame.
- frame_start  out  1  one-cycle request to the LED driver.
- frame_base  out  log2(COLUMNS*AMOUNT_LEDS)  Memory base address; valid while frame_start is high.
- column_index  out  log2(COLUMNS)  column currently scheduled.
- spinning  out  1  globe rotation is locked.
- rev_period  out  PERIOD_WIDTH  last accepted revolution period, in cycles.
- overrun_count  out  8  columns skipped because the driver was busy; saturating.

Behaviour:
- Reset (reset_n low at a clock edge): all outputs 0, state IDLE, in_flight 0, sync flops 0.
- Synchronisation: hall_in passes through a 2-flop synchroniser, then rising-edge detect.
  - hall_event is true when the edge is detected and period_cnt >= MIN_PERIOD.
  - Edges arriving before MIN_PERIOD are dropped; period_cnt is not cleared.
- period_cnt increments every cycle, saturates at TIMEOUT_COUNT, and clears on hall_event.
- col_interval = rev_period >> log2(COLUMNS), truncated.
- in_flight is set on frame_start and cleared on driver_done.
- A frame may be issued only if in_flight == 0 and driver_busy == 0 in that cycle. Otherwise the column is skipped and overrun_count increments.
- frame_base = col_addr * AMOUNT_LEDS. Without the optional feature, col_addr = column_index. The multiply is by a constant.
- States:
  - IDLE: waits for hall_event, then clears period_cnt and goes to MEASURE. No frames are issued.
  - MEASURE: on hall_event, latches rev_period = period_cnt, sets column_index = 0, sets spinning = 1, and goes to RUN. On period_cnt == TIMEOUT_COUNT, goes to IDLE.
  - RUN:
    - On hall_event: latches the new rev_period, sets column_index to 0, reloads the column timer, and issues column 0.
    - On column-timer expiry: increments column_index and issues the new column.
    - At column_index == COLUMNS-1: holds with no wrap and no further issue until hall_event.
    - On period_cnt == TIMEOUT_COUNT: sets spinning = 0, clears column_index, and goes to IDLE.
- Latency: a hall pulse first sampled high at edge N produces frame_start at edge N+3.
- Column timer loads col_interval-1 and issues at 0. Columns are therefore spaced exactly col_interval cycles apart.
- Hall event and timer expiry in the same cycle: the hall event wins and the expiry is discarded.
- driver_done and an issue in the same cycle: in_flight is evaluated before the clear, so the issue is skipped.
- Reset mid-frame: frame_start drops immediately. An in-flight driver frame completes unobserved.

Optional Feature:
- Macro: POV_PHASE_OFFSET_EN.
- When defined: adds input port phase_offset [log2(COLUMNS)-1:0], registered at each hall_event. col_addr = (column_index + phase_offset) mod COLUMNS, which rotates the image around the globe.
- When undefined: no port; col_addr = column_index.

Decomposition:
- Shared package pov_pkg: state encodings (STATE_IDLE/MEASURE/RUN), log2 function, column and address width constants.
- One sub-module: pov_hall_sync (2-flop synchroniser, edge detect, MIN_PERIOD gate; output hall_event).

Test Plan:
Bench parameters: COLUMNS=4, AMOUNT_LEDS=5, MIN_PERIOD=20, TIMEOUT_COUNT=1000.
- Hall pulses 400 cycles apart, driver idle -> after the 2nd pulse: rev_period=400, spinning=1, frame_start at +3, +103, +203, +303 with frame_base 0, 5, 10, 15.
- Extra hall pulse 10 cycles after a valid one -> ignored; rev_period unchanged; no column-0 reissue.
- driver_busy held high across column 2 -> no frame_start for column 2; overrun_count=1; column 3 issues normally.
- No hall for 1000 cycles while in RUN -> spinning=0, column_index=0, no further frame_start; the next two pulses re-lock.
- reset_n low during RUN for 1 cycle -> all outputs 0 on the next edge; state IDLE; two pulses needed before frames resume.
- POV_PHASE_OFFSET_EN with phase_offset=3 -> column 0 frame_base=15, column 1 frame_base=0.
